// File: rtl/ace_result_serializer.sv
// ace_result_serializer
//
// Takes full-width product words on a valid/ready handshake and holds them
// in a small circular FIFO. One shift stage then pulls each word out of the
// FIFO and sends it as bytes, least-significant byte first, on an 8-bit
// valid/ready stream. out_last marks the most-significant byte of each word.
//
// Handshake semantics (both ports): a transfer happens on a rising clock
// edge where valid && ready are both high. Once valid is raised it stays
// high, and the payload stays stable, until that transfer happens. ready
// never depends combinationally on valid.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   clear               synchronous flush of the FIFO and the word in flight
//   in_valid/in_data    product word input
//   in_ready            high when the FIFO is not full (registered flag)
//   out_valid/out_data  byte output stream
//   out_last            current byte is the top byte of its word
//   out_ready           consumer accepts the current byte
//   level               FIFO occupancy, excluding the word in the shift stage
//   busy                shift stage is sending, or the FIFO is nonempty
//   fsm_state           debug view of the shift-stage state (0=IDLE, 1=SEND)
module ace_result_serializer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       fsm_state
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic push, pop, last_byte, fifo_empty;

  assign fifo_empty = (level_q == '0);
  assign last_byte  = (idx_q == IDX_W'(NB - 1));
  // Only the registered full flag gates input, so a pop in a full cycle
  // does not open the input until the following cycle.
  assign push       = in_valid && !full_q;

  // Shift-stage next state. Loading the next word on the last-byte
  // handshake keeps the byte stream free of bubbles between words.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!last_byte) begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IDX_W'(1);
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_W'(DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage array carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= in_data;
  end

  assign in_ready  = !full_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = (state_q == SEND) ? shift_q[7:0] : 8'h00;
  assign out_last  = (state_q == SEND) && last_byte;
  assign level     = level_q;
  assign busy      = (state_q == SEND) || !fifo_empty;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_ace_result_serializer.sv
// Directed testbench for ace_result_serializer (DATA_W=16, DEPTH=4).
module tb_ace_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [2:0]  level;
  logic        busy;
  logic        fsm_state;

  int tests;
  int fails;

  // expected byte stream: {last, byte}
  logic [8:0] exp_q[$];

  ace_result_serializer #(.DATA_W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .level     (level),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_latency_early: got valid %b want 0", out_valid); end
    tick();
    tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'hEF}) begin fails++; $display("FAIL single_byte0: got v%b l%b %h want v1 l0 ef", out_valid, out_last, out_data); end
    tick();
    tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'hBE}) begin fails++; $display("FAIL single_byte1: got v%b l%b %h want v1 l1 be", out_valid, out_last, out_data); end
    tick();
    tests++; if ({out_valid, busy} !== 2'b00) begin fails++; $display("FAIL single_idle: got valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h34}) begin fails++; $display("FAIL bp_hold_%0d: got v%b l%b %h want v1 l0 34", i, out_valid, out_last, out_data); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++; if ({out_valid, out_data} !== {1'b1, 8'h34}) begin fails++; $display("FAIL bp_release: got v%b %h want v1 34", out_valid, out_data); end
    tick();
    tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h12}) begin fails++; $display("FAIL bp_byte1: got v%b l%b %h want v1 l1 12", out_valid, out_last, out_data); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    int accepted;
    accepted = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    tests++; if (accepted !== 5) begin fails++; $display("FAIL fill_accepted: got %0d want 5", accepted); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL fill_level: got %0d want 4", level); end
    out_ready = 1'b1;
    #1;
    for (int w = 1; w <= 5; w++) begin
      tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'(w)}) begin fails++; $display("FAIL fill_lo_w%0d: got v%b l%b %h want v1 l0 %h", w, out_valid, out_last, out_data, 8'(w)); end
      tick();
      tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h00}) begin fails++; $display("FAIL fill_hi_w%0d: got v%b l%b %h want v1 l1 00", w, out_valid, out_last, out_data); end
      tick();
    end
    tests++; if ({out_valid, busy} !== 2'b00) begin fails++; $display("FAIL fill_drained: got valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic test_full_pop();
    int sent;
    int got;
    int budget;
    logic [8:0] e;
    sent = 0; got = 0; exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'hC000 + 16'(sent);
      if (in_ready) begin
        exp_q.push_back({1'b0, in_data[7:0]});
        exp_q.push_back({1'b1, in_data[15:8]});
        sent++;
      end
      tick();
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fullpop_full: got in_ready %b want 0", in_ready); end
    out_ready = 1'b1;
    budget = 0;
    while ((got < 40) && (budget < 400)) begin
      budget++;
      in_valid = (sent < 20);
      in_data  = 16'hC000 + 16'(sent);
      #1;
      if (level > 3'd4) begin tests++; fails++; $display("FAIL fullpop_level: got %0d want <=4", level); end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        tests++;
        if ({out_last, out_data} !== e) begin fails++; $display("FAIL fullpop_byte%0d: got l%b %h want l%b %h", got, out_last, out_data, e[8], e[7:0]); end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_data[7:0]});
        exp_q.push_back({1'b1, in_data[15:8]});
        sent++;
      end
      @(posedge clk);
      #0;
      if (budget == 1) begin
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fullpop_ready_before_pop: got %b want 0", in_ready); end
      end else if (budget == 2) begin
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fullpop_ready_after_pop: got %b want 1", in_ready); end
      end else begin
        #1;
      end
    end
    in_valid = 1'b0;
    tests++; if (got !== 40) begin fails++; $display("FAIL fullpop_count: got %0d bytes want 40", got); end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL fullpop_leftover: got %0d want 0", exp_q.size()); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fullpop_busy: got %b want 0", busy); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hBEEF; tick();
    in_data = 16'h1111; tick();
    in_data = 16'h2222; tick();
    tests++; if ({out_valid, out_data, level} !== {1'b1, 8'hEF, 3'd2}) begin fails++; $display("FAIL clear_setup: got v%b %h lvl%0d want v1 ef lvl2", out_valid, out_data, level); end
    clear = 1'b1; in_data = 16'h3333;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    tests++; if ({out_valid, busy, level} !== {1'b0, 1'b0, 3'd0}) begin fails++; $display("FAIL clear_flush: got v%b busy%b lvl%0d want v0 busy0 lvl0", out_valid, busy, level); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL clear_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'hA55A; tick();
    in_valid = 1'b0; tick();
    tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h5A}) begin fails++; $display("FAIL clear_after_b0: got v%b l%b %h want v1 l0 5a", out_valid, out_last, out_data); end
    tick();
    tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'hA5}) begin fails++; $display("FAIL clear_after_b1: got v%b l%b %h want v1 l1 a5", out_valid, out_last, out_data); end
    tick();
    tests++; if ({out_valid, busy} !== 2'b00) begin fails++; $display("FAIL clear_after_idle: got v%b busy%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h5678; tick();
    in_data = 16'h9ABC; tick();
    in_valid = 1'b0;
    tests++; if ({out_valid, out_data} !== {1'b1, 8'h78}) begin fails++; $display("FAIL areset_setup: got v%b %h want v1 78", out_valid, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({out_valid, out_last, out_data} !== {1'b0, 1'b0, 8'h00}) begin fails++; $display("FAIL areset_out: got v%b l%b %h want v0 l0 00", out_valid, out_last, out_data); end
    tests++; if ({level, busy, in_ready} !== {3'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL areset_status: got lvl%0d busy%b rdy%b want lvl0 busy0 rdy1", level, busy, in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h00FF; tick();
    in_valid = 1'b0; tick();
    tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'hFF}) begin fails++; $display("FAIL areset_b0: got v%b l%b %h want v1 l0 ff", out_valid, out_last, out_data); end
    tick();
    tests++; if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h00}) begin fails++; $display("FAIL areset_b1: got v%b l%b %h want v1 l1 00", out_valid, out_last, out_data); end
    tick();
    tests++; if ({out_valid, busy} !== 2'b00) begin fails++; $display("FAIL areset_idle: got v%b busy%b want 0 0", out_valid, busy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_fill();
    test_full_pop();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ace_result_serializer.md
# ace_result_serializer

Output stage that sits downstream of the multiplier datapath. It accepts full-width product words on a valid/ready handshake and buffers them in a small FIFO. Each word is then serialized onto an 8-bit byte stream, LSB byte first, with its own valid/ready handshake and a last-byte marker. Its purpose is to carry products wider than 8 bits out through the 8-bit dedicated output pins without stalling the datapath.

## Interface
- DATA_W, 16, product word width; must be a multiple of 8, at least 16
- DEPTH, 4, FIFO depth in words; power of two, at least 2
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low; one clock domain only
- clear  input  1  synchronous flush; drops the FIFO contents and the word in flight
- in_valid  input  1  product word present on in_data
- in_data  input  DATA_W  product word
- in_ready  output  1  block can accept a word; equals !fifo_full
- out_valid  output  1  out_data holds a valid byte
- out_data  output  8  current byte
- out_last  output  1  current byte is the most-significant byte of its word
- out_ready  input  1  consumer accepts the byte
- level  output  $clog2(DEPTH+1)  FIFO occupancy in words; excludes the word in the shift stage
- busy  output  1  shift stage holds a word, or level is nonzero

## Operation
- Storage is a DEPTH-entry circular FIFO with wrapping write and read pointers, plus one shift stage: a DATA_W shift register and a byte index of width $clog2(DATA_W/8).
- Push: when in_valid && in_ready, in_data is written at the write pointer and the write pointer increments.
- The shift stage has two states:
  - IDLE: out_valid=0. If the FIFO is nonempty, the head word is popped and loaded, the byte index is set to 0, and the state moves to SEND.
  - SEND: out_valid=1 and out_data = shift_reg[7:0]. out_last=1 when byte index = DATA_W/8-1.
    - Byte handshake (out_valid && out_ready) on a non-last byte: shift right by 8 and increment the byte index.
    - Handshake on the last byte with the FIFO nonempty: pop and load the next word on the same edge and stay in SEND, with no bubble.
    - Handshake on the last byte with the FIFO empty: go to IDLE.
- Output stability: while out_valid && !out_ready, out_data and out_last do not change.
- Push and pop on the same edge: level is unchanged. in_ready is derived only from the registered full flag, so it stays low in a cycle where the FIFO is full and a pop is happening. There is no combinational bypass.
- clear:
  - Takes priority over push and pop.
  - Next edge: pointers reset to 0, level=0, state IDLE, out_valid=0.
  - Any word presented in the clear cycle is dropped.
- Reset values: out_valid=0, out_data=0x00, out_last=0, level=0, busy=0, state IDLE, pointers 0.
  - in_ready=1 while in reset and after reset.
  - Reset during SEND discards the word in flight and all buffered words.

## Timing
- Latency: a word accepted at edge N into an empty block is loaded at edge N+1, so out_valid is high after edge N+1.
- Throughput: one byte per cycle while out_ready=1, so a word drains in DATA_W/8 cycles.
- Capacity: DEPTH+1 words (FIFO plus shift stage) can be accepted before in_ready falls, with out_ready held at 0.
- All outputs are registered or derived from registered state. The only combinational input-to-output paths are:
  - none to out_*
  - none to in_ready

## Test plan
- Single word: after reset, push 0xBEEF with out_ready=1 -> out_valid rises one cycle after the accept. Bytes are 0xEF (out_last=0) then 0xBE (out_last=1). Then out_valid=0 and busy=0.
- Backpressure: push 0x1234, hold out_ready=0 for 5 cycles -> out_data holds 0x34 and out_valid stays 1. Release -> 0x34, then 0x12 with last.
- Fill: with out_ready=0, push 0x0001 to 0x0006 back-to-back -> 5 words accepted, in_ready=0 after the 5th, level=4. Drain -> bytes 01,00,02,00,…,05,00 in order, each word's high byte with out_last=1.
- Full with simultaneous pop: keep FIFO full, out_ready=1, in_valid=1 -> in_ready stays low until the first pop edge, and level never exceeds 4. No words are lost or duplicated across 20 words, which exercises pointer wrap.
- clear mid-word: assert clear while byte 0xEF of 0xBEEF is pending with level=2 -> next cycle out_valid=0, level=0, busy=0. A following push of 0xA55A emits 0x5A, then 0xA5.
- Async reset mid-SEND: drop rst_n between clock edges -> outputs go to reset values immediately, without waiting for a clock edge. After release, a push of 0x00FF emits 0xFF, then 0x00 with last.
